// File: rtl/game_pkg.sv
// Shared encodings for the bulls-and-cows controller: game states, glyph codes
// and the text layout of the VGA overlay.
package game_pkg;

  typedef enum logic [1:0] {
    ST_SET  = 2'b00,
    ST_PLAY = 2'b01,
    ST_WIN  = 2'b10,
    ST_LOSE = 2'b11
  } state_t;

  localparam logic [6:0] CH_NUL = 7'h00, CH_0 = 7'h30, CH_1 = 7'h31, CH_A = 7'h41,
                         CH_B = 7'h42, CH_C = 7'h43, CH_D = 7'h44, CH_E = 7'h45,
                         CH_G = 7'h47, CH_I = 7'h49, CH_M = 7'h4D, CH_N = 7'h4E,
                         CH_O = 7'h4F, CH_R = 7'h52, CH_S = 7'h53, CH_T = 7'h54,
                         CH_U = 7'h55, CH_V = 7'h56, CH_W = 7'h57, CH_Y = 7'h59,
                         CH_EXCL = 7'h21, CH_SLASH = 7'h2F;

  localparam logic [3:0] ROW_STATUS = 4'd1, ROW_GUESS = 4'd2, ROW_SCORE = 4'd3,
                         ROW_TRY = 4'd4, ROW_SECRET = 4'd5;
  localparam logic [4:0] COL_VAL = 5'd8;

  // Status strings indexed by state; spaces are blank glyphs so they stay dark.
  localparam logic [6:0] STATUS_STR [4][9] = '{
    '{CH_S, CH_E, CH_T, CH_NUL, CH_C, CH_O, CH_D, CH_E, CH_NUL},
    '{CH_G, CH_U, CH_E, CH_S, CH_S, CH_NUL, CH_NUL, CH_NUL, CH_NUL},
    '{CH_Y, CH_O, CH_U, CH_NUL, CH_W, CH_I, CH_N, CH_EXCL, CH_NUL},
    '{CH_G, CH_A, CH_M, CH_E, CH_NUL, CH_O, CH_V, CH_E, CH_R}
  };

  function automatic logic [6:0] status_char(state_t st, logic [4:0] col);
    return (col < 5'd9) ? STATUS_STR[st][col[3:0]] : CH_NUL;
  endfunction

endpackage

// File: rtl/bc_scorer.sv
// Combinational bulls/cows scorer; valid flags a guess with all digits <=9
// and pairwise distinct, so the same block also vets a new secret.
module bc_scorer #(
  parameter int DIGITS = 3,
  parameter int CNT_W  = 3
) (
  input  logic [DIGITS-1:0][3:0] secret,
  input  logic [DIGITS-1:0][3:0] guess,
  output logic [CNT_W-1:0]       bulls,
  output logic [CNT_W-1:0]       cows,
  output logic                   valid
);

  always_comb begin
    bulls = '0;
    cows  = '0;
    valid = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (guess[i] > 4'd9) valid = 1'b0;
      if (guess[i] == secret[i]) bulls = bulls + CNT_W'(1);
      for (int j = 0; j < DIGITS; j++) begin
        if (i != j) begin
          if (guess[i] == secret[j]) cows = cows + CNT_W'(1);
          if (guess[i] == guess[j]) valid = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/bulls_cows_game.sv
// Bulls-and-cows game controller: secret entry, guess scoring, try counting
// and a 4x-scaled text overlay fed through an external synchronous font ROM.
module bulls_cows_game import game_pkg::*; #(
  parameter int DIGITS    = 3,
  parameter int MAX_TRIES = 8,
  parameter int CNT_W     = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [9:0]          pix_x,
  input  logic [9:0]          pix_y,
  input  logic [4*DIGITS-1:0] guess_in,
  input  logic                guess_vld,
  output logic                guess_rdy,
  input  logic                new_game,
  output logic                err_o,
  output logic [1:0]          state_o,
  output logic [3:0]          tries_o,
  output logic [CNT_W-1:0]    bulls_o,
  output logic [CNT_W-1:0]    cows_o,
  output logic [10:0]         font_addr,
  input  logic [7:0]          font_word,
  output logic                text_on,
  output logic [2:0]          text_rgb
);

  localparam bit M_HI = (MAX_TRIES >= 10);
  localparam int M_LO = M_HI ? MAX_TRIES - 10 : MAX_TRIES;

  state_t                  state;
  logic [DIGITS-1:0][3:0]  secret, last, guess;
  logic [CNT_W-1:0]        sc_bulls, sc_cows, bulls, cows;
  logic                    sc_valid, err, hs;
  logic [3:0]              tries;

  assign guess = guess_in;

  bc_scorer #(.DIGITS(DIGITS), .CNT_W(CNT_W)) u_scorer (
    .secret(secret), .guess(guess), .bulls(sc_bulls), .cows(sc_cows), .valid(sc_valid)
  );

  assign guess_rdy = (state == ST_SET) || (state == ST_PLAY);
  assign hs        = guess_vld && guess_rdy;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ST_SET;
      tries  <= '0;
      bulls  <= '0;
      cows   <= '0;
      secret <= '0;
      last   <= '0;
      err    <= 1'b0;
    end else begin
      err <= 1'b0;
      if (new_game) begin
        // secret is deliberately kept; the next SET handshake overwrites it
        state <= ST_SET;
        tries <= '0;
        bulls <= '0;
        cows  <= '0;
        last  <= '0;
      end else if (hs) begin
        if (!sc_valid) begin
          err <= 1'b1;
        end else if (state == ST_SET) begin
          secret <= guess;
          state  <= ST_PLAY;
        end else begin
          last  <= guess;
          bulls <= sc_bulls;
          cows  <= sc_cows;
          tries <= tries + 4'd1;
          if (sc_bulls == CNT_W'(DIGITS))           state <= ST_WIN;
          else if (tries + 4'd1 == 4'(MAX_TRIES))   state <= ST_LOSE;
        end
      end
    end
  end

  assign err_o   = err;
  assign state_o = state;
  assign tries_o = tries;
  assign bulls_o = bulls;
  assign cows_o  = cows;

  // Stage 0: character lookup from the current pixel
  logic [4:0] col, sl;
  logic [3:0] trow, grow, t_lo;
  logic [6:0] ch;
  logic       t_hi, active, active_d, unused_pix;
  logic [2:0] bit_d;

  assign col        = pix_x[9:5];
  assign trow       = pix_y[9:6];
  assign grow       = pix_y[5:2];
  assign unused_pix = ^{pix_x[1:0], pix_y[1:0]};

  always_comb begin
    ch   = CH_NUL;
    t_hi = (tries >= 4'd10);
    t_lo = t_hi ? tries - 4'd10 : tries;
    sl   = t_hi ? 5'd6 : 5'd5;
    case (trow)
      ROW_STATUS: ch = status_char(state, col);
      ROW_GUESS, ROW_SECRET: begin
        for (int k = 0; k < DIGITS; k++) begin
          if (col == 5'(COL_VAL + k)) begin
            if (trow == ROW_GUESS && state != ST_SET)   ch = CH_0 + 7'(last[k]);
            if (trow == ROW_SECRET && state == ST_LOSE) ch = CH_0 + 7'(secret[k]);
          end
        end
      end
      ROW_SCORE: begin
        if (col == COL_VAL)              ch = CH_0 + 7'(bulls);
        else if (col == COL_VAL + 5'd1)  ch = CH_A;
        else if (col == COL_VAL + 5'd3)  ch = CH_0 + 7'(cows);
        else if (col == COL_VAL + 5'd4)  ch = CH_B;
      end
      ROW_TRY: begin
        // "TRY t/m": the slash moves right when tries needs two digits
        if (col == 5'd0)                     ch = CH_T;
        else if (col == 5'd1)                ch = CH_R;
        else if (col == 5'd2)                ch = CH_Y;
        else if (col == 5'd4)                ch = t_hi ? CH_1 : CH_0 + 7'(tries);
        else if (col == 5'd5 && t_hi)        ch = CH_0 + 7'(t_lo);
        else if (col == sl)                  ch = CH_SLASH;
        else if (col == sl + 5'd1)           ch = M_HI ? CH_1 : CH_0 + 7'(M_LO);
        else if (col == sl + 5'd2 && M_HI)   ch = CH_0 + 7'(M_LO);
      end
      default: ;
    endcase
    active = (ch != CH_NUL);
  end

  assign font_addr = active ? {ch, grow} : 11'd0;

  // Stage 1: align with the ROM's one-cycle read latency
  always_ff @(posedge clk) begin
    if (!reset) begin
      active_d <= 1'b0;
      bit_d    <= '0;
    end else begin
      active_d <= active;
      bit_d    <= pix_x[4:2];
    end
  end

  assign text_on  = active_d;
  assign text_rgb = (active_d && font_word[~bit_d]) ? 3'b000 : 3'b111;

endmodule

// File: tb/tb_bulls_cows_game.sv
// Scoreboard bench: stimulus pushes expected scores, per-DUT monitors pop and
// compare one cycle after each handshake; display checks are direct.
module tb_bulls_cows_game;

  typedef struct packed {
    logic       err;
    logic [1:0] st;
    logic [3:0] tr;
    logic [2:0] b;
    logic [2:0] c;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, guess_vld, new_game, guess_vld4, new_game4;
  logic [9:0]  pix_x, pix_y;
  logic [11:0] guess_in;
  logic [15:0] guess_in4;
  logic [7:0]  font_word, font_word4;
  logic        guess_rdy, err_o, text_on, guess_rdy4, err_o4, text_on4;
  logic [1:0]  state_o, state_o4;
  logic [3:0]  tries_o, tries_o4;
  logic [2:0]  bulls_o, cows_o, bulls_o4, cows_o4, text_rgb, text_rgb4;
  logic [10:0] font_addr, font_addr4;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  exp_t q4[$];
  logic [11:0] gl [8];
  int   gb [8];
  int   gc [8];

  bulls_cows_game #(.DIGITS(3), .MAX_TRIES(8), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y),
    .guess_in(guess_in), .guess_vld(guess_vld), .guess_rdy(guess_rdy),
    .new_game(new_game), .err_o(err_o), .state_o(state_o), .tries_o(tries_o),
    .bulls_o(bulls_o), .cows_o(cows_o), .font_addr(font_addr),
    .font_word(font_word), .text_on(text_on), .text_rgb(text_rgb)
  );

  bulls_cows_game #(.DIGITS(4), .MAX_TRIES(2), .CNT_W(3)) dut4 (
    .clk(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y),
    .guess_in(guess_in4), .guess_vld(guess_vld4), .guess_rdy(guess_rdy4),
    .new_game(new_game4), .err_o(err_o4), .state_o(state_o4), .tries_o(tries_o4),
    .bulls_o(bulls_o4), .cows_o(cows_o4), .font_addr(font_addr4),
    .font_word(font_word4), .text_on(text_on4), .text_rgb(text_rgb4)
  );

  function automatic logic [7:0] rom(logic [10:0] a);
    return a[7:0] ^ a[10:3];
  endfunction

  always @(posedge clk) begin
    font_word  <= rom(font_addr);
    font_word4 <= rom(font_addr4);
  end

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  initial begin : mon
    bit   pend;
    exp_t e;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        if (q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("sb_err",   32'(err_o),   32'(e.err));
          chk("sb_state", 32'(state_o), 32'(e.st));
          chk("sb_tries", 32'(tries_o), 32'(e.tr));
          chk("sb_bulls", 32'(bulls_o), 32'(e.b));
          chk("sb_cows",  32'(cows_o),  32'(e.c));
        end
      end
      pend = guess_vld && guess_rdy && reset;
    end
  end

  initial begin : mon4
    bit   pend;
    exp_t e;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        if (q4.size() == 0) chk("sb4_underflow", 32'd1, 32'd0);
        else begin
          e = q4.pop_front();
          chk("sb4_err",   32'(err_o4),   32'(e.err));
          chk("sb4_state", 32'(state_o4), 32'(e.st));
          chk("sb4_tries", 32'(tries_o4), 32'(e.tr));
          chk("sb4_bulls", 32'(bulls_o4), 32'(e.b));
          chk("sb4_cows",  32'(cows_o4),  32'(e.c));
        end
      end
      pend = guess_vld4 && guess_rdy4 && reset;
    end
  end

  task automatic submit(input bit u4, input logic [15:0] code, input int err,
                        input int st, input int tr, input int b, input int c, input bit ng);
    exp_t e;
    e = '{err: 1'(err), st: 2'(st), tr: 4'(tr), b: 3'(b), c: 3'(c)};
    if (u4) q4.push_back(e);
    else    q.push_back(e);
    @(posedge clk); #1;
    if (u4) begin guess_in4 = code; guess_vld4 = 1'b1; end
    else begin guess_in = code[11:0]; guess_vld = 1'b1; new_game = ng; end
    @(posedge clk); #1;
    guess_vld = 1'b0; guess_vld4 = 1'b0; new_game = 1'b0;
  endtask

  task automatic pulse_ng();
    @(posedge clk); #1 new_game = 1'b1;
    @(posedge clk); #1 new_game = 1'b0;
    @(negedge clk);
  endtask

  task automatic ck_ch(input bit u4, input int col, input int trow,
                       input logic [6:0] exp_ch, input string nm);
    logic [10:0] a;
    pix_x = 10'(col * 32);
    pix_y = 10'(trow * 64);
    #1;
    a = u4 ? font_addr4 : font_addr;
    chk(nm, 32'(a), 32'({exp_ch, 4'b0000}));
  endtask

  initial begin
    reset = 1'b0; guess_vld = 1'b0; guess_vld4 = 1'b0; new_game = 1'b0; new_game4 = 1'b0;
    guess_in = '0; guess_in4 = '0; pix_x = '0; pix_y = '0;
    gl = '{12'h987, 12'h546, 12'h564, 12'h210, 12'h754, 12'h645, 12'h409, 12'h654};
    gb = '{0, 0, 1, 0, 2, 1, 0, 3};
    gc = '{0, 3, 2, 0, 0, 2, 1, 0};

    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_state",  32'(state_o),  0);
    chk("rst_tries",  32'(tries_o),  0);
    chk("rst_bulls",  32'(bulls_o),  0);
    chk("rst_cows",   32'(cows_o),   0);
    chk("rst_rdy",    32'(guess_rdy), 1);
    chk("rst_err",    32'(err_o),    0);
    chk("rst_on",     32'(text_on),  0);
    chk("rst_rgb",    32'(text_rgb), 7);
    chk("rst_state4", 32'(state_o4), 0);

    // 'S' of "SET CODE": row 1, col 0, glyph row 5, bit 3
    @(posedge clk); #1;
    pix_x = 10'd12; pix_y = 10'd84;
    #1;
    chk("pix_addr_S", 32'(font_addr), 32'h535);
    chk("pix_on_lag", 32'(text_on), 0);
    @(posedge clk); @(negedge clk);
    chk("pix_on_d1",  32'(text_on), 1);
    chk("pix_rgb",    32'(text_rgb), 0);
    ck_ch(0, 3, 0, 7'h00, "blank_row0");

    // secret 1,2,3 then guess 1,3,5
    submit(0, 16'h321, 0, 1, 0, 0, 0, 0);
    submit(0, 16'h531, 0, 1, 1, 1, 1, 0);
    ck_ch(0, 8,  3, 7'h31, "r3_bulls");
    ck_ch(0, 9,  3, 7'h41, "r3_A");
    ck_ch(0, 10, 3, 7'h00, "r3_gap");
    ck_ch(0, 11, 3, 7'h31, "r3_cows");
    ck_ch(0, 12, 3, 7'h42, "r3_B");
    ck_ch(0, 4,  4, 7'h31, "r4_tries");
    ck_ch(0, 5,  4, 7'h2F, "r4_slash");
    ck_ch(0, 6,  4, 7'h38, "r4_max");
    ck_ch(0, 0,  1, 7'h47, "r1_G");
    ck_ch(0, 8,  2, 7'h31, "r2_d0");
    ck_ch(0, 10, 2, 7'h35, "r2_d2");

    // restart, secret 4,5,6, rejected codes
    pulse_ng();
    chk("ng_state", 32'(state_o), 0);
    chk("ng_tries", 32'(tries_o), 0);
    chk("ng_bulls", 32'(bulls_o), 0);
    ck_ch(0, 8, 2, 7'h00, "r2_blank_set");
    submit(0, 16'h654, 0, 1, 0, 0, 0, 0);
    submit(0, 16'h877, 1, 1, 0, 0, 0, 0);
    @(posedge clk); @(negedge clk);
    chk("err_one_cycle", 32'(err_o), 0);
    submit(0, 16'h2A1, 1, 1, 0, 0, 0, 0);

    // seven misses then the secret on the final try: WIN beats LOSE
    for (int i = 0; i < 8; i++)
      submit(0, {4'h0, gl[i]}, 0, (i == 7) ? 2 : 1, i + 1, gb[i], gc[i], 0);
    @(negedge clk);
    chk("win_rdy", 32'(guess_rdy), 0);
    @(posedge clk); #1 guess_in = 12'h987; guess_vld = 1'b1;
    @(posedge clk); #1 guess_vld = 1'b0;
    @(negedge clk);
    chk("win_hold_state", 32'(state_o), 2);
    chk("win_hold_tries", 32'(tries_o), 8);
    chk("win_hold_bulls", 32'(bulls_o), 3);
    chk("win_hold_err",   32'(err_o),   0);
    ck_ch(0, 0, 1, 7'h59, "r1_Y");
    ck_ch(0, 4, 4, 7'h38, "r4_tries8");

    // new_game together with a winning guess: guess dropped
    pulse_ng();
    submit(0, 16'h321, 0, 1, 0, 0, 0, 0);
    submit(0, 16'h531, 0, 1, 1, 1, 1, 0);
    submit(0, 16'h321, 0, 0, 0, 0, 0, 1);

    // 4-digit, 2-try build
    submit(1, 16'h4321, 0, 1, 0, 0, 0, 0);
    submit(1, 16'h1234, 0, 1, 1, 0, 4, 0);
    submit(1, 16'h8765, 0, 3, 2, 0, 0, 0);
    ck_ch(1, 8,  5, 7'h31, "r5_sec0");
    ck_ch(1, 11, 5, 7'h34, "r5_sec3");
    ck_ch(0, 8,  5, 7'h00, "r5_hidden");
    ck_ch(1, 8,  2, 7'h35, "r2_d4");
    ck_ch(1, 6,  4, 7'h32, "r4_max2");
    ck_ch(1, 0,  1, 7'h47, "r1_G_over");
    @(posedge clk); #1 guess_in4 = 16'h4321; guess_vld4 = 1'b1;
    @(posedge clk); #1 guess_vld4 = 1'b0;
    @(negedge clk);
    chk("lose_hold_state", 32'(state_o4), 3);
    chk("lose_hold_tries", 32'(tries_o4), 2);
    chk("lose_hold_err",   32'(err_o4),   0);

    @(negedge clk);
    chk("sb_drained", 32'(q.size() + q4.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bulls_cows_game.md
Name: bulls_cows_game

Overview:
- Parametrised Bulls-and-Cows game controller with a VGA text overlay; successor to the fixed 3-digit A/B hint block.
- Accepts a secret code, then scores player guesses (bulls = right digit right place, cows = right digit wrong place).
- Tracks the attempt count and a WIN/LOSE outcome, and renders status, last guess, score and tries through an external synchronous font ROM.
- Sits between the keypad/number-entry block and the VGA pixel mux.

Parameters:
- DIGITS, 3, code length in digits; legal range 2..4.
- MAX_TRIES, 8, guesses allowed before LOSE; legal range 1..15.
- CNT_W, 3, width of the bulls/cows counts; must satisfy 2^CNT_W > DIGITS.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- pix_x  in  10  current VGA pixel column.
- pix_y  in  10  current VGA pixel row.
- guess_in  in  4*DIGITS  packed BCD digits; digit 0 at [3:0] is displayed leftmost.
- guess_vld  in  1  guess_in valid this cycle.
- guess_rdy  out  1  block can accept a code this cycle.
- new_game  in  1  single-cycle restart request.
- err_o  out  1  one-cycle pulse when a submitted code is rejected.
- state_o  out  2  00 SET, 01 PLAY, 10 WIN, 11 LOSE.
- tries_o  out  4  number of guesses scored.
- bulls_o  out  CNT_W  bulls for the last scored guess.
- cows_o  out  CNT_W  cows for the last scored guess.
- font_addr  out  11  {char[6:0], row[3:0]} sent to the font ROM.
- font_word  in  8  ROM data; valid exactly 1 clk after font_addr.
- text_on  out  1  overlay pixel active, aligned to the delayed pixel.
- text_rgb  out  3  overlay colour: 000 for a glyph bit, 111 for background.

Behaviour:
- Reset (reset==0 at a clk edge) sets: state=SET, tries=0, bulls=0, cows=0, secret=0, last guess=0, err_o=0, text_on=0, text_rgb=111, the pixel pipeline registers=0.
- guess_rdy=1 only in SET and PLAY. A handshake occurs when guess_vld && guess_rdy.
- Validation: a code is valid only if every digit is <=9 and all digits are pairwise distinct.
  - Invalid code: no state change; err_o pulses on the next cycle.
- SET: a valid handshake latches the secret; state becomes PLAY next cycle. tries, bulls and cows are unchanged (0).
- PLAY: a valid handshake latches the guess into the last-guess register.
  - bulls = count of i where g[i]==s[i].
  - cows = count of (i,j), i!=j, where g[i]==s[j].
  - bulls, cows and tries+1 are all registered together, 1 clk after the handshake.
  - If bulls==DIGITS, state becomes WIN in that same cycle.
  - Otherwise, if the new tries==MAX_TRIES, state becomes LOSE.
  - WIN takes priority over LOSE on the final try.
- WIN and LOSE are terminal: handshakes are ignored and err_o stays 0.
- new_game in any state: state=SET; tries, bulls, cows and the last guess are cleared next cycle; the secret is retained until it is overwritten.
  - new_game and a handshake in the same cycle: new_game wins and the guess is dropped.
- Reset asserted while a score is pending: reset wins and no score is registered.
- Display: 8x16 glyphs, scaled x4 (char column = pix_x[9:5], glyph row = pix_y[5:2], bit = pix_x[4:2]). Text rows are selected by pix_y[9:6]:
  - Row 1: status string: "SET CODE", "GUESS", "YOU WIN!", "GAME OVER".
  - Row 2, columns 8..8+DIGITS-1: last-guess digits (0x30+d). Blank in SET.
  - Row 3: "<bulls>A <cows>B" starting at column 8.
  - Row 4: "TRY <tries>/<MAX_TRIES>". Values >=10 print as two digits.
  - Row 5: secret digits, shown in LOSE only.
  - Any other area: font_addr=0 and text_on=0.
- Pixel pipeline: stage 0 drives font_addr combinationally from pix_x/pix_y. Stage 1 registers the region-active flag and bit_addr. font_bit = font_word[~bit_addr_d].
  - text_on and text_rgb therefore lag pix_x/pix_y by exactly 1 clk.

Decomposition:
- Package game_pkg holds:
  - the state encoding (SET, PLAY, WIN, LOSE);
  - ASCII constants: blank 0x00, '0' 0x30, 'A' 0x41, 'B' 0x42, letters for the status strings;
  - row-index constants for the display layout.
- Sub-module bc_scorer is purely combinational: secret, guess -> bulls, cows, valid. It is reused for both secret validation and scoring.
- font_rom stays external.

Test Plan:
1. Reset low 2 clks -> state_o=00, tries_o=0, guess_rdy=1, text_rgb=111.
2. Secret 1,2,3, then guess 1,3,5 -> 1 clk later bulls_o=1, cows_o=1, tries_o=1, state_o=01. Row 3 renders "1A 1B".
3. Secret 4,5,6; submit 7,7,8 in PLAY -> err_o pulses 1 clk; tries_o stays 0; bulls_o/cows_o unchanged.
4. Secret 4,5,6; guess 4,5,6 on try 8 with MAX_TRIES=8 -> state_o=10 (WIN, not LOSE), tries_o=8, guess_rdy=0.
5. MAX_TRIES=2; two wrong guesses -> state_o=11. Row 5 shows the secret. A further guess_vld is ignored.
6. new_game asserted with guess_vld in the same cycle, in PLAY -> state_o=00, tries_o=0, and no score is registered.
7. DIGITS=4 build, secret 1,2,3,4, guess 4,3,2,1 -> bulls_o=0, cows_o=4.
8. Drive pix_x/pix_y over row 1, column 0 -> font_addr={0x53,row} for the 'S' of "SET CODE"; text_on asserts exactly 1 clk later.
